// File: rtl/uart_pkg.sv
// uart_pkg: bus register offsets, config reset defaults and tx engine states shared by the uart peripherals
package uart_pkg;
  localparam logic [31:0] REG_DATA = 32'h00;
  localparam logic [31:0] REG_BUSY = 32'h08;
  localparam logic [31:0] REG_BAUD = 32'h0C;
  localparam logic [31:0] REG_PARITY = 32'h10;
  localparam logic [31:0] REG_STOP = 32'h14;
  localparam logic [31:0] REG_RESET = 32'h24;
  localparam logic [16:0] BAUD_DEFAULT = 17'd9600;
  localparam logic PARITY_DEFAULT = 1'b1;
  localparam logic STOP_DEFAULT = 1'b1;
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} tx_state_t;
endpackage

// File: rtl/uart_tx.sv
// uart_tx: frame engine (baud accumulator, FSM, shifter); start_i/data_i begin a frame using baudrate_i/parity_en_i/stopbit_i, drives tx_o, busy_o, done_o pulses on the tick ending the last stop bit
module uart_tx import uart_pkg::*; #(
  parameter int unsigned CLK_FREQ_HZ = 10_000_000
) (
  input  logic        clk_i,
  input  logic        rst,
  input  logic        start_i,
  input  logic [7:0]  data_i,
  input  logic [16:0] baudrate_i,
  input  logic        parity_en_i,
  input  logic        stopbit_i,
  output logic        tx_o,
  output logic        busy_o,
  output logic        done_o
);
  tx_state_t state, state_n;
  logic [31:0] acc;
  logic [32:0] sum;
  logic [16:0] baud;
  logic [7:0] sh;
  logic [2:0] cnt;
  logic scnt, par_en, stop2, par, tick;
  assign sum = {1'b0, acc} + 33'(baud);
  assign tick = sum >= 33'(CLK_FREQ_HZ);
  assign busy_o = state != IDLE;
  assign done_o = tick && state == STOP && scnt == stop2;
  assign tx_o = state == START ? 1'b0 : state == DATA ? sh[0] : state == PARITY ? par : 1'b1;
  always_comb begin
    state_n = state;
    if (state == IDLE)
      state_n = start_i ? START : IDLE;
    else if (tick)
      state_n = state == START ? DATA :
                state == DATA ? (cnt == 3'd7 ? (par_en ? PARITY : STOP) : DATA) :
                state == PARITY ? STOP :
                (scnt == stop2 ? IDLE : STOP);
  end
  always_ff @(posedge clk_i) begin
    if (rst) state <= IDLE;
    else state <= state_n;
  end
  always_ff @(posedge clk_i) begin
    if (rst) begin
      acc <= '0;
      baud <= BAUD_DEFAULT;
      par_en <= PARITY_DEFAULT;
      stop2 <= STOP_DEFAULT;
      sh <= '0;
      par <= 1'b0;
      cnt <= '0;
      scnt <= 1'b0;
    end else if (state == IDLE) begin
      if (start_i) begin
        acc <= '0;
        baud <= baudrate_i;
        par_en <= parity_en_i;
        stop2 <= stopbit_i;
        sh <= data_i;
        par <= ^data_i;
        cnt <= '0;
        scnt <= 1'b0;
      end
    end else begin
      acc <= tick ? 32'(sum - 33'(CLK_FREQ_HZ)) : sum[31:0];
      if (tick && state == DATA) begin
        sh <= sh >> 1;
        cnt <= cnt + 3'd1;
      end
      if (tick && state == STOP) scnt <= 1'b1;
    end
  end
endmodule

// File: rtl/uart_tx_sb_ctrl.sv
// uart_tx_sb_ctrl: bus-mapped uart transmitter; addr_i/req_i/write_data_i/write_enable_i bus in, read_data_o registered read, interrupt_request_o/interrupt_return_i frame-done irq, tx_o serial line
module uart_tx_sb_ctrl import uart_pkg::*; #(
  parameter int unsigned CLK_FREQ_HZ = 10_000_000
) (
  input  logic        clk_i,
  input  logic        rst,
  input  logic [31:0] addr_i,
  input  logic        req_i,
  input  logic [31:0] write_data_i,
  input  logic        write_enable_i,
  output logic [31:0] read_data_o,
  output logic        interrupt_request_o,
  input  logic        interrupt_return_i,
  output logic        tx_o
);
  logic [16:0] baudrate;
  logic [7:0] data;
  logic [31:0] rdata;
  logic parity_en, stopbit, wr, rd, cfg_wr, start, soft_rst, rst_all, busy, done, unused_ok;
  assign wr = req_i & write_enable_i;
  assign rd = req_i & ~write_enable_i;
  assign cfg_wr = wr & ~busy;
  assign start = cfg_wr && addr_i == REG_DATA;
  assign soft_rst = wr && addr_i == REG_RESET && write_data_i[0];
  assign rst_all = rst | soft_rst;
  assign unused_ok = ^write_data_i[31:17];
  always_comb
    rdata = addr_i == REG_DATA ? {24'd0, data} :
            addr_i == REG_BUSY ? {31'd0, busy} :
            addr_i == REG_BAUD ? {15'd0, baudrate} :
            addr_i == REG_PARITY ? {31'd0, parity_en} :
            addr_i == REG_STOP ? {31'd0, stopbit} : '0;
  always_ff @(posedge clk_i) begin
    if (rst_all) begin
      baudrate <= BAUD_DEFAULT;
      parity_en <= PARITY_DEFAULT;
      stopbit <= STOP_DEFAULT;
      data <= '0;
      read_data_o <= '0;
      interrupt_request_o <= 1'b0;
    end else begin
      if (start) data <= write_data_i[7:0];
      if (cfg_wr && addr_i == REG_BAUD && write_data_i[16:0] != '0) baudrate <= write_data_i[16:0];
      if (cfg_wr && addr_i == REG_PARITY) parity_en <= write_data_i[0];
      if (cfg_wr && addr_i == REG_STOP) stopbit <= write_data_i[0];
      if (rd) read_data_o <= rdata;
      interrupt_request_o <= done | (interrupt_request_o & ~interrupt_return_i & ~start);
    end
  end
  uart_tx #(.CLK_FREQ_HZ(CLK_FREQ_HZ)) u_tx (
    .clk_i(clk_i),
    .rst(rst_all),
    .start_i(start),
    .data_i(write_data_i[7:0]),
    .baudrate_i(baudrate),
    .parity_en_i(parity_en),
    .stopbit_i(stopbit),
    .tx_o(tx_o),
    .busy_o(busy),
    .done_o(done)
  );
endmodule

// File: tb/tb_uart_tx_sb_ctrl.sv
// tb_uart_tx_sb_ctrl: register table, directed corner sequences and random frames checked against a bit-list frame model
module tb_uart_tx_sb_ctrl;
  localparam int unsigned CLK = 96000;
  typedef struct {
    logic [31:0] addr;
    logic [31:0] exp;
  } vec_t;
  logic clk_i = 1'b0, rst = 1'b1, req_i = 1'b0, write_enable_i = 1'b0, interrupt_return_i = 1'b0;
  logic [31:0] addr_i = '0, write_data_i = '0, read_data_o, r;
  logic interrupt_request_o, tx_o;
  int passed = 0, total = 0;
  int m_baud = 9600;
  logic m_par = 1'b1, m_stop = 1'b1;
  vec_t vt[7];
  int bauds[6] = '{9600, 4800, 12000, 16000, 24000, 48000};
  always #5 clk_i = ~clk_i;
  uart_tx_sb_ctrl #(.CLK_FREQ_HZ(CLK)) dut (
    .clk_i(clk_i),
    .rst(rst),
    .addr_i(addr_i),
    .req_i(req_i),
    .write_data_i(write_data_i),
    .write_enable_i(write_enable_i),
    .read_data_o(read_data_o),
    .interrupt_request_o(interrupt_request_o),
    .interrupt_return_i(interrupt_return_i),
    .tx_o(tx_o)
  );
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask
  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk_i);
    req_i = 1'b1; write_enable_i = 1'b1; addr_i = a; write_data_i = d;
    @(negedge clk_i);
    req_i = 1'b0; write_enable_i = 1'b0;
  endtask
  task automatic rd(input logic [31:0] a, output logic [31:0] d);
    @(negedge clk_i);
    req_i = 1'b1; write_enable_i = 1'b0; addr_i = a;
    @(negedge clk_i);
    req_i = 1'b0;
    d = read_data_o;
  endtask
  task automatic cfg(input int baud, input logic par, input logic stop);
    wr(32'h0C, baud);
    wr(32'h10, {31'd0, par});
    wr(32'h14, {31'd0, stop});
    if (baud != 0) m_baud = baud;
    m_par = par;
    m_stop = stop;
  endtask
  task automatic run_frame(input logic [7:0] d, input logic inject, input logic ret_end);
    logic bits[$];
    int cpb, len, txbad, irqbad;
    logic [31:0] q;
    cpb = CLK / m_baud;
    txbad = 0;
    irqbad = 0;
    bits.push_back(1'b0);
    for (int i = 0; i < 8; i++) bits.push_back(d[i]);
    if (m_par) bits.push_back(^d);
    bits.push_back(1'b1);
    if (m_stop) bits.push_back(1'b1);
    len = bits.size() * cpb;
    wr(32'h00, {24'd0, d});
    for (int i = 0; i < len; i++) begin
      if (tx_o !== bits[i / cpb]) txbad++;
      if (interrupt_request_o !== 1'b0) irqbad++;
      req_i = 1'b0; write_enable_i = 1'b0; interrupt_return_i = 1'b0;
      if (inject && i == len / 3) begin
        req_i = 1'b1; write_enable_i = 1'b1; addr_i = 32'h0C; write_data_i = 32'd4800;
      end else if (inject && i == len / 3 + 1) begin
        req_i = 1'b1; write_enable_i = 1'b1; addr_i = 32'h00; write_data_i = 32'hAA;
      end else if (i == len - 1) begin
        req_i = 1'b1; addr_i = 32'h08; interrupt_return_i = ret_end;
      end
      @(negedge clk_i);
    end
    req_i = 1'b0; write_enable_i = 1'b0; interrupt_return_i = 1'b0;
    chk($sformatf("frame_tx_%0h", d), txbad, 0);
    chk($sformatf("frame_irq_low_%0h", d), irqbad, 0);
    chk("busy_last_cycle", read_data_o, 32'd1);
    chk("tx_idle_after", {31'd0, tx_o}, 32'd1);
    chk("irq_after_frame", {31'd0, interrupt_request_o}, 32'd1);
    rd(32'h08, q);
    chk("busy_after_frame", q, 32'd0);
  endtask
  initial begin
    int lowcnt;
    vt[0] = '{32'h08, 32'd0};
    vt[1] = '{32'h0C, 32'd9600};
    vt[2] = '{32'h10, 32'd1};
    vt[3] = '{32'h14, 32'd1};
    vt[4] = '{32'h00, 32'd0};
    vt[5] = '{32'h04, 32'd0};
    vt[6] = '{32'h24, 32'd0};
    repeat (3) @(negedge clk_i);
    rst = 1'b0;
    chk("rst_tx", {31'd0, tx_o}, 32'd1);
    chk("rst_irq", {31'd0, interrupt_request_o}, 32'd0);
    chk("rst_rdata", read_data_o, 32'd0);
    for (int i = 0; i < 7; i++) begin
      rd(vt[i].addr, r);
      chk($sformatf("reg_%0h", vt[i].addr), r, vt[i].exp);
    end
    run_frame(8'h55, 1'b0, 1'b0);
    run_frame(8'h3C, 1'b1, 1'b0);
    rd(32'h0C, r);
    chk("busy_baud_ignored", r, 32'd9600);
    rd(32'h00, r);
    chk("busy_data_ignored", r, 32'h3C);
    lowcnt = 0;
    repeat (150) begin
      @(negedge clk_i);
      if (tx_o !== 1'b1) lowcnt++;
    end
    chk("single_frame_only", lowcnt, 0);
    @(negedge clk_i);
    interrupt_return_i = 1'b1;
    @(negedge clk_i);
    interrupt_return_i = 1'b0;
    chk("irq_return_clear", {31'd0, interrupt_request_o}, 32'd0);
    cfg(9600, 1'b0, 1'b0);
    run_frame(8'h80, 1'b0, 1'b0);
    rd(32'h10, r);
    chk("parity_off", r, 32'd0);
    rd(32'h14, r);
    chk("stop_one", r, 32'd0);
    wr(32'h0C, 32'd0);
    rd(32'h0C, r);
    chk("baud_zero_ignored", r, 32'd9600);
    run_frame(8'hA7, 1'b0, 1'b1);
    cfg(4800, 1'b0, 1'b1);
    wr(32'h00, 32'h00);
    repeat (84) @(negedge clk_i);
    chk("tx_data_bit3", {31'd0, tx_o}, 32'd0);
    wr(32'h24, 32'd1);
    chk("soft_rst_tx", {31'd0, tx_o}, 32'd1);
    chk("soft_rst_irq", {31'd0, interrupt_request_o}, 32'd0);
    m_baud = 9600; m_par = 1'b1; m_stop = 1'b1;
    rd(32'h08, r);
    chk("soft_rst_busy", r, 32'd0);
    rd(32'h0C, r);
    chk("soft_rst_baud", r, 32'd9600);
    rd(32'h10, r);
    chk("soft_rst_parity", r, 32'd1);
    rd(32'h14, r);
    chk("soft_rst_stop", r, 32'd1);
    lowcnt = 0;
    repeat (300) begin
      @(negedge clk_i);
      if (tx_o !== 1'b1 || interrupt_request_o !== 1'b0) lowcnt++;
    end
    chk("soft_rst_quiet", lowcnt, 0);
    wr(32'h00, 32'hF0);
    repeat (120) @(negedge clk_i);
    chk("b2b_irq", {31'd0, interrupt_request_o}, 32'd1);
    req_i = 1'b1; write_enable_i = 1'b1; addr_i = 32'h00; write_data_i = 32'h0F;
    @(negedge clk_i);
    req_i = 1'b0; write_enable_i = 1'b0;
    chk("b2b_start", {31'd0, tx_o}, 32'd0);
    chk("b2b_irq_clear", {31'd0, interrupt_request_o}, 32'd0);
    repeat (130) @(negedge clk_i);
    rd(32'h00, r);
    chk("b2b_data", r, 32'h0F);
    for (int f = 0; f < 12; f++) begin
      cfg(bauds[$urandom_range(5)], 1'($urandom_range(1)), 1'($urandom_range(1)));
      run_frame(8'($urandom), 1'b0, 1'b0);
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
